i2c_ball_slave: RTL and testbench
=================================

Name: i2c_ball_slave

Overview:
- Receive-side I2C slave on the opponent board; sits directly downstream of the I2C master's SDA/SCL bus.
- Decodes write frames carrying the ball hand-off (ball_y, ball_vy, gravity_counter, collision and lose flags).
- ACKs each byte and presents a fully checked frame to the game logic as one-cycle-valid registered outputs.
- Oversamples the bus on the system clock; no SCL clock domain.

Parameters:
SLAVE_ADDR, 7'h55, 7-bit address this slave answers to
SYNC_STAGES, 2, flip-flop depth of SDA/SCL input synchronizers (min 2)

Ports:
clk  input  1  system clock, 50 MHz
reset  input  1  synchronous, active-low reset
SCL  input  1  I2C clock from master
SDA  inout  1  I2C data; slave only drives 0 (ACK) or Z
ball_y  output  10  received ball vertical position
ball_vy  output  8  received ball vertical velocity
gravity_counter  output  2  received gravity phase
is_collusion  output  1  received collision flag
lose_flag  output  1  received "sender lost" flag
frame_valid  output  1  one-cycle pulse: new frame latched on outputs
frame_error  output  1  one-cycle pulse: addressed frame aborted or malformed
busy  output  1  high from matched address ACK until STOP or abort

Behaviour:
- Reset (reset=0 at posedge clk):
  - All outputs 0; SDA released (Z).
  - FSM returns to IDLE; shift register and byte count cleared.
  - Reset mid-frame discards the partial frame with no pulses.
- Input path:
  - SCL and SDA each pass through SYNC_STAGES flops, plus one history flop for edge detection.
  - Bus-event latency is SYNC_STAGES+1 clk.
- Bus events (synchronized signals):
  - START: SDA falls while SCL high.
  - STOP: SDA rises while SCL high.
  - Bit sample: SCL rising edge.
  - Drive change: SCL falling edge.
- Frame format:
  - Address byte {addr[6:0], rw}, then exactly 3 payload bytes, MSB first.
  - byte0 = ball_y[7:0]
  - byte1 = {gravity_counter[1:0], is_collusion, lose_flag, 2'b00, ball_y[9:8]}; bits [3:2] ignored
  - byte2 = ball_vy[7:0]
- FSM states:
  - IDLE: wait for START -> ADDR.
  - ADDR: shift 8 bits on SCL rising edges.
    - After bit 8: if addr==SLAVE_ADDR and rw==0 -> ADDR_ACK; else -> WAIT_STOP, no ACK, no error.
  - ADDR_ACK:
    - On the next SCL falling edge, drive SDA=0 and set busy=1.
    - Hold SDA low through one full SCL high period; release on the following falling edge.
    - -> DATA with byte count 0.
  - DATA: shift 8 bits into shadow byte[count] -> DATA_ACK.
  - DATA_ACK:
    - If count<3: drive ACK as in ADDR_ACK, count++, -> DATA.
    - If count>=3 (4th payload byte): no ACK, set error flag, -> WAIT_STOP.
  - WAIT_STOP: SDA released; wait for STOP or START.
- STOP handling (any state except IDLE):
  - count==3 and no error: copy shadow bytes to outputs; frame_valid=1 for exactly one clk in the cycle after STOP is detected.
  - Addressed frame otherwise (0–2 data bytes, or error flag set): frame_error=1 for one clk; outputs keep previous values.
  - Unaddressed frame: no pulse.
  - busy=0 in the same cycle; -> IDLE.
- Repeated START in any non-IDLE state:
  - Release SDA and discard shadow bytes.
  - frame_error pulse if busy; -> ADDR.
- Outputs change only on frame_valid, so a partial frame never corrupts them.
- frame_valid and frame_error are never high together.
- SDA is never driven while SCL is high, except during the held ACK bit.

Test Plan:
- Write to 0x55, bytes 0x34, 0xE2, 0x7F, then STOP -> three ACKs (SDA=0 in each 9th clock); then frame_valid one pulse with ball_y=0x234, gravity_counter=2'b11, is_collusion=1, lose_flag=0, ball_vy=0x7F; busy falls at STOP.
- Address 0x54 write, two bytes, STOP -> SDA never driven low; no pulses; outputs unchanged; busy stays 0.
- Address 0x55 with rw=1 -> NACK, no pulses.
- Matched frame, STOP after byte1 -> frame_error single pulse; ball_y/ball_vy hold the previous frame values.
- Matched frame, 4 data bytes -> 4th byte NACKed; frame_error at STOP; outputs unchanged.
- Repeated START after byte0, then a full valid frame 0x00, 0x10, 0x05 -> one frame_error at the repeated START, then frame_valid with ball_y=0x000, lose_flag=1, ball_vy=0x05.
- reset=0 asserted mid-byte1 -> SDA released next clk, all outputs 0; next complete frame is received normally.

Source files
------------

// File: rtl/i2c_ball_slave.sv
// Oversampled write-only I2C slave receiving the 3-byte ball hand-off frame.
// Outputs are updated only when a complete, error-free frame is closed by STOP.
module i2c_ball_slave #(
  parameter logic [6:0]  SLAVE_ADDR  = 7'h55,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       SCL,
  inout  wire        SDA,
  output logic [9:0] ball_y,
  output logic [7:0] ball_vy,
  output logic [1:0] gravity_counter,
  output logic       is_collusion,
  output logic       lose_flag,
  output logic       frame_valid,
  output logic       frame_error,
  output logic       busy
);
  typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, WAIT_STOP} state_t;
  state_t state, state_n;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic       scl_s, sda_s, scl_p, sda_p;
  logic       start_ev, stop_ev, scl_rise, scl_fall;
  logic [7:0] shift, next_byte;
  logic [2:0] bit_cnt;
  logic [1:0] byte_cnt;
  logic [7:0] shadow [3];
  logic       err, sda_drive;
  logic       restart, frame_end, frame_ok, frame_bad;
  logic       drive_set, drive_clr, cnt_inc, err_set, sample;

  assign SDA = sda_drive ? 1'b0 : 1'bz;

  // Synchronizers idle high so reset release never fabricates a bus event
  always_ff @(posedge clk) begin
    if (!reset) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_p    <= 1'b1;
      sda_p    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], SCL};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], SDA};
      scl_p    <= scl_s;
      sda_p    <= sda_s;
    end
  end

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign start_ev  = scl_s && scl_p && sda_p && !sda_s;
  assign stop_ev   = scl_s && scl_p && !sda_p && sda_s;
  assign scl_rise  = scl_s && !scl_p;
  assign scl_fall  = !scl_s && scl_p;
  assign next_byte = {shift[6:0], sda_s};

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n   = state;
    restart   = 1'b0;
    frame_end = 1'b0;
    frame_ok  = 1'b0;
    frame_bad = 1'b0;
    drive_set = 1'b0;
    drive_clr = 1'b0;
    cnt_inc   = 1'b0;
    err_set   = 1'b0;
    sample    = 1'b0;
    if (start_ev) begin
      state_n = ADDR;
      restart = 1'b1;
    end else if (stop_ev && state != IDLE) begin
      state_n   = IDLE;
      frame_end = 1'b1;
      frame_ok  = busy && byte_cnt == 2'd3 && !err;
      frame_bad = busy && !(byte_cnt == 2'd3 && !err);
    end else begin
      sample = scl_rise && (state == ADDR || state == DATA);
      unique case (state)
        ADDR:
          if (scl_rise && bit_cnt == 3'd7)
            state_n = (next_byte == {SLAVE_ADDR, 1'b0}) ? ADDR_ACK : WAIT_STOP;
        ADDR_ACK:
          if (scl_fall) begin
            if (!sda_drive) drive_set = 1'b1;
            else begin
              drive_clr = 1'b1;
              state_n   = DATA;
            end
          end
        DATA:
          if (scl_rise && bit_cnt == 3'd7) state_n = DATA_ACK;
        DATA_ACK:
          if (byte_cnt == 2'd3) begin
            err_set = 1'b1;
            state_n = WAIT_STOP;
          end else if (scl_fall) begin
            if (!sda_drive) drive_set = 1'b1;
            else begin
              drive_clr = 1'b1;
              cnt_inc   = 1'b1;
              state_n   = DATA;
            end
          end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      shift           <= '0;
      bit_cnt         <= '0;
      byte_cnt        <= '0;
      err             <= 1'b0;
      sda_drive       <= 1'b0;
      busy            <= 1'b0;
      frame_valid     <= 1'b0;
      frame_error     <= 1'b0;
      ball_y          <= '0;
      ball_vy         <= '0;
      gravity_counter <= '0;
      is_collusion    <= 1'b0;
      lose_flag       <= 1'b0;
      for (int unsigned i = 0; i < 3; i++) shadow[i] <= '0;
    end else begin
      frame_valid <= frame_ok;
      frame_error <= frame_bad || (restart && busy);
      if (restart) begin
        shift    <= '0;
        bit_cnt  <= '0;
        byte_cnt <= '0;
        err      <= 1'b0;
        for (int unsigned i = 0; i < 3; i++) shadow[i] <= '0;
      end else if (sample) begin
        shift   <= next_byte;
        bit_cnt <= bit_cnt + 3'd1;
        if (state == DATA && bit_cnt == 3'd7 && byte_cnt != 2'd3)
          shadow[byte_cnt] <= next_byte;
      end
      if (cnt_inc) byte_cnt <= byte_cnt + 2'd1;
      if (err_set) err <= 1'b1;
      if (restart || frame_end) begin
        sda_drive <= 1'b0;
        busy      <= 1'b0;
      end else if (drive_set) begin
        sda_drive <= 1'b1;
        busy      <= 1'b1;
      end else if (drive_clr) begin
        sda_drive <= 1'b0;
      end
      if (frame_ok) begin
        ball_y          <= {shadow[1][1:0], shadow[0]};
        gravity_counter <= shadow[1][7:6];
        is_collusion    <= shadow[1][5];
        lose_flag       <= shadow[1][4];
        ball_vy         <= shadow[2];
      end
    end
  end
endmodule

// File: tb/tb_i2c_ball_slave.sv
// Bit-banged I2C master with a scoreboard of expected frame pulses and a
// frame-level reference model of the ball hand-off decode.
module tb_i2c_ball_slave;
  localparam logic [6:0] ADDR = 7'h55;
  localparam int Q = 6;

  logic clk = 1'b0, reset = 1'b0, scl = 1'b1, m_low = 1'b0;
  wire  sda;
  logic [9:0] ball_y;
  logic [7:0] ball_vy;
  logic [1:0] gravity_counter;
  logic       is_collusion, lose_flag, frame_valid, frame_error, busy;

  assign sda = m_low ? 1'b0 : 1'bz;
  pullup (sda);

  always #10 clk = ~clk;

  i2c_ball_slave #(.SLAVE_ADDR(ADDR), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .SCL(scl), .SDA(sda),
    .ball_y(ball_y), .ball_vy(ball_vy), .gravity_counter(gravity_counter),
    .is_collusion(is_collusion), .lose_flag(lose_flag),
    .frame_valid(frame_valid), .frame_error(frame_error), .busy(busy)
  );

  typedef struct { bit valid; int y; int vy; int g; int c; int l; } exp_t;
  exp_t exp_q[$];
  int m_y = 0, m_vy = 0, m_g = 0, m_c = 0, m_l = 0;
  int errors = 0, checks = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_hold(input string tag);
    chk({tag, "_ball_y"}, int'(ball_y), m_y);
    chk({tag, "_ball_vy"}, int'(ball_vy), m_vy);
    chk({tag, "_gravity"}, int'(gravity_counter), m_g);
    chk({tag, "_collusion"}, int'(is_collusion), m_c);
    chk({tag, "_lose"}, int'(lose_flag), m_l);
  endtask

  // Scoreboard monitor: every pulse must match the oldest expected event
  always @(negedge clk) begin
    exp_t e;
    if (reset && (frame_valid || frame_error)) begin
      if (frame_valid && frame_error) chk("pulse_exclusive", 1, 0);
      else if (exp_q.size() == 0) chk("unexpected_pulse", int'({frame_valid, frame_error}), 0);
      else begin
        e = exp_q.pop_front();
        chk("pulse_kind_valid", int'(frame_valid), int'(e.valid));
        chk("pulse_ball_y", int'(ball_y), e.y);
        chk("pulse_ball_vy", int'(ball_vy), e.vy);
        chk("pulse_gravity", int'(gravity_counter), e.g);
        chk("pulse_collusion", int'(is_collusion), e.c);
        chk("pulse_lose", int'(lose_flag), e.l);
      end
    end
  end

  task automatic wait_q(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    m_low = 1'b0; wait_q(Q);
    scl = 1'b1;   wait_q(Q);
    m_low = 1'b1; wait_q(Q);
    scl = 1'b0;   wait_q(Q);
  endtask

  task automatic i2c_stop();
    m_low = 1'b1; wait_q(Q);
    scl = 1'b1;   wait_q(Q);
    m_low = 1'b0; wait_q(Q);
  endtask

  task automatic wbit(input bit b);
    m_low = !b; wait_q(Q);
    scl = 1'b1; wait_q(2 * Q);
    scl = 1'b0; wait_q(Q);
  endtask

  task automatic wbyte(input logic [7:0] d, output bit ack);
    for (int i = 7; i >= 0; i--) wbit(d[i]);
    m_low = 1'b0; wait_q(Q);
    scl = 1'b1;   wait_q(Q);
    ack = (sda == 1'b0);
    wait_q(Q);
    scl = 1'b0;   wait_q(Q);
  endtask

  // Frame-level model: addressed iff write to our address; first three payload
  // bytes ACKed; a STOP after exactly three bytes is the only valid ending.
  task automatic send_frame(input logic [7:0] ab, input int n, input logic [31:0] pl, input bit stop);
    bit   ack, addressed;
    int   b [4];
    exp_t e;
    addressed = (ab == {ADDR, 1'b0});
    for (int i = 0; i < 4; i++) b[i] = int'(pl[31 - 8 * i -: 8]);
    i2c_start();
    chk("busy_after_start", int'(busy), 0);
    wbyte(ab, ack);
    chk("addr_ack", int'(ack), int'(addressed));
    chk("busy_after_addr", int'(busy), int'(addressed));
    for (int i = 0; i < n; i++) begin
      wbyte(pl[31 - 8 * i -: 8], ack);
      chk("data_ack", int'(ack), int'(addressed && i < 3));
    end
    if (addressed) begin
      e.valid = stop && n == 3;
      if (e.valid) begin
        m_y  = (b[1] % 4) * 256 + b[0];
        m_g  = b[1] / 64;
        m_c  = (b[1] / 32) % 2;
        m_l  = (b[1] / 16) % 2;
        m_vy = b[2];
      end
      e.y = m_y; e.vy = m_vy; e.g = m_g; e.c = m_c; e.l = m_l;
      exp_q.push_back(e);
    end
    if (stop) begin
      i2c_stop();
      wait_q(4 * Q);
      chk("busy_after_stop", int'(busy), 0);
      chk_hold("hold");
    end
  endtask

  initial begin
    bit ack;
    int r, n;
    logic [7:0] ab;
    logic [7:0] b1;
    wait_q(5);
    chk("reset_sda", int'(sda), 1);
    chk("reset_busy", int'(busy), 0);
    chk("reset_pulses", int'({frame_valid, frame_error}), 0);
    chk_hold("reset");
    reset = 1'b1;
    wait_q(5);

    send_frame(8'hAA, 3, 32'h34E27F00, 1'b1);
    send_frame(8'hA8, 2, 32'h11223344, 1'b1);
    send_frame(8'hAB, 3, 32'h55667788, 1'b1);
    send_frame(8'hAA, 2, 32'h99AABBCC, 1'b1);
    send_frame(8'hAA, 4, 32'h01020304, 1'b1);
    send_frame(8'hAA, 1, 32'h12000000, 1'b0);
    send_frame(8'hAA, 3, 32'h00100500, 1'b1);

    // Reset asserted while the slave holds the ACK of byte 1
    i2c_start();
    wbyte(8'hAA, ack);
    wbyte(8'h5A, ack);
    b1 = 8'hC3;
    for (int i = 7; i >= 0; i--) wbit(b1[i]);
    m_low = 1'b0; wait_q(Q);
    scl = 1'b1;   wait_q(Q);
    chk("rst_pre_ack", int'(sda), 0);
    reset = 1'b0;
    wait_q(1);
    chk("rst_sda_release", int'(sda), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_pulses", int'({frame_valid, frame_error}), 0);
    m_y = 0; m_vy = 0; m_g = 0; m_c = 0; m_l = 0;
    chk_hold("rst");
    wait_q(3);
    reset = 1'b1;
    scl = 1'b0; wait_q(Q);
    i2c_stop();
    send_frame(8'hAA, 3, 32'hFF3C8100, 1'b1);

    for (int k = 0; k < 24; k++) begin
      r = int'($urandom_range(0, 9));
      if (r < 7)       ab = 8'hAA;
      else if (r == 7) ab = 8'hAB;
      else             ab = {7'($urandom_range(0, 127)), 1'b0};
      n = ($urandom_range(0, 1) == 1) ? 3 : int'($urandom_range(0, 4));
      send_frame(ab, n, $urandom(), ($urandom_range(0, 4) != 0) || k == 23);
    end

    wait_q(50);
    chk("queue_drain", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
